// File: rtl/io_pkg.sv
// Register map shared by the MMIO I/O controller and its sub-blocks.
package io_pkg;

    localparam int unsigned RegIdxW = 3;

    typedef enum logic [RegIdxW-1:0] {
        RegDipState = 3'd0,
        RegLed      = 3'd1,
        RegHex      = 3'd2,
        RegChg      = 3'd3,
        RegChgEn    = 3'd4,
        RegScratch  = 3'd5
    } reg_idx_e;

    localparam int unsigned DbCntW = 8;

endpackage

// File: rtl/io_debounce.sv
// One DIP bit: 2-flop synchroniser, run-length debounce counter and a toggle pulse
// asserted on the edge where the debounced state flips.
module io_debounce
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic state_o,
    output logic toggle_o
);

    localparam logic [DbCntW-1:0] DbLimit = DbCntW'(DEBOUNCE_CYCLES);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              state_q, state_d;
    logic [DbCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = din_i;
        sync2_d  = sync1_q;
        state_d  = state_q;
        cnt_d    = '0;
        toggle_o = 1'b0;
        // Any sample matching the current state drops the run, rejecting glitches.
        if (sync2_q != state_q) begin
            if (cnt_q + DbCntW'(1) == DbLimit) begin
                state_d  = ~state_q;
                toggle_o = 1'b1;
            end else begin
                cnt_d = cnt_q + DbCntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller for debounced DIP switches, LEDs, a seven-segment hex register,
// sticky change flags with interrupt enable, and a scratch register.
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter int unsigned N_DIP           = 7,
    parameter int unsigned N_LED           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_DIP-1:0] DIP,
    input  logic [31:0]      ADDR,
    input  logic [31:0]      WDATA,
    input  logic             WE,
    input  logic             RE,
    output logic [31:0]      RDATA,
    output logic             RVALID,
    output logic [N_LED-1:0] LED,
    output logic [31:0]      SEVENSEGHEX,
    output logic             IRQ
);

    logic [N_DIP-1:0] dip_state;
    logic [N_DIP-1:0] dip_toggle;

    for (genvar i = 0; i < N_DIP; i++) begin : g_db
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .din_i   (DIP[i]),
            .state_o (dip_state[i]),
            .toggle_o(dip_toggle[i])
        );
    end

    logic [N_LED-1:0] led_q, led_d;
    logic [31:0]      hex_q, hex_d;
    logic [N_DIP-1:0] chg_q, chg_d;
    logic [N_DIP-1:0] chg_en_q, chg_en_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [N_DIP-1:0] chg_clr;
    logic [31:0]      rd_mux;
    reg_idx_e         reg_idx;
    logic             unused_addr;

    assign reg_idx     = reg_idx_e'(ADDR[4:2]);
    assign unused_addr = ^{ADDR[31:5], ADDR[1:0]};

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            RegDipState: rd_mux = 32'(dip_state);
            RegLed:      rd_mux = 32'(led_q);
            RegHex:      rd_mux = hex_q;
            RegChg:      rd_mux = 32'(chg_q);
            RegChgEn:    rd_mux = 32'(chg_en_q);
            RegScratch:  rd_mux = scratch_q;
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        led_d     = led_q;
        hex_d     = hex_q;
        chg_en_d  = chg_en_q;
        scratch_d = scratch_q;
        chg_clr   = '0;
        rdata_d   = RE ? rd_mux : rdata_q;
        rvalid_d  = RE;
        if (WE) begin
            case (reg_idx)
                RegLed:     led_d     = WDATA[N_LED-1:0];
                RegHex:     hex_d     = WDATA;
                RegChg:     chg_clr   = WDATA[N_DIP-1:0];
                RegChgEn:   chg_en_d  = WDATA[N_DIP-1:0];
                RegScratch: scratch_d = WDATA;
                default:    ;
            endcase
        end
        // A new toggle in the same cycle as a W1C keeps the flag set.
        chg_d = (chg_q & ~chg_clr) | dip_toggle;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            led_q     <= '0;
            hex_q     <= '0;
            chg_q     <= '0;
            chg_en_q  <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            led_q     <= led_d;
            hex_q     <= hex_d;
            chg_q     <= chg_d;
            chg_en_q  <= chg_en_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign RDATA       = rdata_q;
    assign RVALID      = rvalid_q;
    assign LED         = led_q;
    assign SEVENSEGHEX = hex_q;
    assign IRQ         = |(chg_q & chg_en_q);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed + randomized bench for mmio_io_ctrl against a cycle-level reference model.
module tb_mmio_io_ctrl;

    localparam int unsigned N_DIP = 7;
    localparam int unsigned N_LED = 16;
    localparam int unsigned DB    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_DIP-1:0] dip;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic             rvalid;
    logic [N_LED-1:0] led;
    logic [31:0]      hex;
    logic             irq;

    always #5 clk = ~clk;

    mmio_io_ctrl #(
        .N_DIP          (N_DIP),
        .N_LED          (N_LED),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .DIP        (dip),
        .ADDR       (addr),
        .WDATA      (wdata),
        .WE         (we),
        .RE         (re),
        .RDATA      (rdata),
        .RVALID     (rvalid),
        .LED        (led),
        .SEVENSEGHEX(hex),
        .IRQ        (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [N_DIP-1:0] m_syn1, m_syn2, m_state, m_chg, m_chg_en;
    int               m_run [N_DIP];
    logic [N_LED-1:0] m_led;
    logic [31:0]      m_hex, m_scr, m_rdata;
    logic             m_rvalid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'(m_state);
            3'd1:    return 32'(m_led);
            3'd2:    return m_hex;
            3'd3:    return 32'(m_chg);
            3'd4:    return 32'(m_chg_en);
            3'd5:    return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [N_DIP-1:0] old_syn2;
        logic [N_DIP-1:0] tog;
        logic [N_DIP-1:0] clr;
        logic [31:0]      rd_now;
        if (rst) begin
            m_syn1 = '0; m_syn2 = '0; m_state = '0; m_chg = '0; m_chg_en = '0;
            m_led = '0; m_hex = '0; m_scr = '0; m_rdata = '0; m_rvalid = 1'b0;
            for (int i = 0; i < N_DIP; i++) m_run[i] = 0;
        end else begin
            rd_now   = m_read(addr[4:2]);
            old_syn2 = m_syn2;
            m_syn2   = m_syn1;
            m_syn1   = dip;
            tog      = '0;
            for (int i = 0; i < N_DIP; i++) begin
                if (old_syn2[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_state[i] = ~m_state[i];
                        tog[i]     = 1'b1;
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rvalid = re;
            if (re) m_rdata = rd_now;
            clr = '0;
            if (we) begin
                case (addr[4:2])
                    3'd1: m_led    = wdata[N_LED-1:0];
                    3'd2: m_hex    = wdata;
                    3'd3: clr      = wdata[N_DIP-1:0];
                    3'd4: m_chg_en = wdata[N_DIP-1:0];
                    3'd5: m_scr    = wdata;
                    default: ;
                endcase
            end
            m_chg = (m_chg & ~clr) | tog;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("led", 32'(led), 32'(m_led));
        chk("hex", hex, m_hex);
        chk("irq", 32'(irq), 32'(|(m_chg & m_chg_en)));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cycle();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; re = 1'b1;
        cycle();
        re = 1'b0;
        chk(tag, rdata, exp);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; dip = 7'b0001100; addr = '0; wdata = '0; we = 1'b0; re = 1'b1;
        cycles(2);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_hex", hex, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0; re = 1'b0;
        cycles(6);
        rd("dip_after_rst", 32'h00, 32'h0C);
        rd("chg_after_rst", 32'h0C, 32'h0C);
        chk("irq_after_rst", 32'(irq), 32'h0);

        // 3-cycle glitch must be rejected
        dip[0] = 1'b1; cycles(3);
        dip[0] = 1'b0; cycles(8);
        rd("dip_glitch", 32'h00, 32'h0C);
        rd("chg_glitch", 32'h0C, 32'h0C);

        // Clean edge appears 6 cycles later
        dip[0] = 1'b1; cycles(5);
        rd("dip_edge_m1", 32'h00, 32'h0C);
        rd("dip_edge", 32'h00, 32'h0D);

        wr(32'h04, 32'hFFFFA5A5);
        chk("led_wr", 32'(led), 32'h0000A5A5);
        wr(32'h08, 32'h12345678);
        chk("hex_wr", hex, 32'h12345678);
        rd("led_rd", 32'h04, 32'h0000A5A5);
        rd("hex_rd", 32'h0B, 32'h12345678);

        wr(32'h0C, 32'h7F);
        wr(32'h10, 32'h01);
        dip[0] = 1'b0; cycles(6);
        chk("irq_set", 32'(irq), 32'h1);
        wr(32'h0C, 32'h01);
        chk("irq_clr", 32'(irq), 32'h0);
        dip[0] = 1'b1; cycles(5);
        wr(32'h0C, 32'h01);
        chk("irq_set_wins", 32'(irq), 32'h1);
        rd("chg_set_wins", 32'h0C, 32'h01);

        wr(32'h18, 32'hDEADBEEF);
        wr(32'h00, 32'hDEADBEEF);
        rd("unmapped_rd", 32'h1C, 32'h0);
        rd("dip_ro", 32'h00, 32'h0D);
        rd("scratch_rd", 32'h14, 32'h0);
        rd("led_kept", 32'h04, 32'h0000A5A5);

        wr(32'h14, 32'h11111111);
        addr = 32'h14; wdata = 32'h22222222; we = 1'b1; re = 1'b1;
        cycle();
        we = 1'b0; re = 1'b0;
        chk("rw_same_old", rdata, 32'h11111111);
        rd("rw_same_new", 32'h14, 32'h22222222);

        // Randomized traffic with occasional resets and DIP activity
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom_range(0, 99) == 0);
            we    = $urandom_range(0, 2) == 0;
            re    = $urandom_range(0, 2) == 0;
            addr  = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 5) == 0) dip[$urandom_range(0, N_DIP - 1)] ^= 1'b1;
            cycle();
        end
        rst = 1'b0; we = 1'b0; re = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
MMIO_IO_CTRL -- requirements
Module: mmio_io_ctrl

Interface
REQ-001 Parameter N_DIP, default 7, number of DIP switch inputs (1..32).
REQ-002 Parameter N_LED, default 16, number of LED outputs (1..32).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive equal samples needed to accept a DIP bit change (2..255).
REQ-004 Port CLK, input, 1, single clock; all state updates on rising edge.
REQ-005 Port RESET, input, 1, synchronous, active-high reset.
REQ-006 Port DIP, input, N_DIP, asynchronous switch inputs.
REQ-007 Port ADDR, input, 32, byte address; only ADDR[4:2] decoded, ADDR[1:0] ignored.
REQ-008 Port WDATA, input, 32, write data.
REQ-009 Port WE, input, 1, write strobe, one transfer per asserted cycle.
REQ-010 Port RE, input, 1, read strobe, one transfer per asserted cycle.
REQ-011 Port RDATA, output, 32, read data, valid when RVALID=1.
REQ-012 Port RVALID, output, 1, high exactly one cycle after each RE cycle.
REQ-013 Port LED, output, N_LED, LED register contents.
REQ-014 Port SEVENSEGHEX, output, 32, seven-segment hex register contents.
REQ-015 Port IRQ, output, 1, high while (CHG & CHG_EN) != 0.

Function
REQ-016 Register map (ADDR[4:2]): 0 DIP_STATE RO; 1 LED RW; 2 SEVENSEGHEX RW; 3 CHG sticky W1C; 4 CHG_EN RW; 5 SCRATCH RW; 6-7 unmapped.
REQ-017 Each DIP bit passes a 2-flop synchroniser before debouncing; sync latency 2 cycles.
REQ-018 Per bit, a counter tracks consecutive cycles the synced value differs from DIP_STATE; on reaching DEBOUNCE_CYCLES, DIP_STATE bit takes the synced value and the counter clears.
REQ-019 Any cycle the synced value equals DIP_STATE clears that bit's counter (glitch rejection).
REQ-020 Total DIP-to-DIP_STATE latency for a clean edge: 2 + DEBOUNCE_CYCLES cycles.
REQ-021 The cycle a DIP_STATE bit toggles, the matching CHG bit sets.
REQ-022 Writing 1 to a CHG bit clears it; writing 0 has no effect; on simultaneous set and clear, set wins.
REQ-023 Writes take effect on the rising edge of the WE cycle; LED, SEVENSEGHEX, CHG_EN, SCRATCH outputs update the next cycle.
REQ-024 Writes to LED store WDATA[N_LED-1:0]; CHG_EN and CHG store [N_DIP-1:0]; upper bits ignored.
REQ-025 Reads return the value registered at the RE edge, zero-extended to 32 bits; same-cycle read and write to one address returns the old value.
REQ-026 Reads of unmapped addresses return 0 with RVALID=1; writes to unmapped or RO addresses are ignored.
REQ-027 WE and RE both high in one cycle: both performed, per REQ-023 and REQ-025.
REQ-028 RDATA holds its last value when RVALID=0.

Reset
REQ-029 While RESET=1 at a clock edge: LED, SEVENSEGHEX, CHG, CHG_EN, SCRATCH, RDATA = 0; RVALID = 0; IRQ = 0.
REQ-030 Reset clears synchronisers, debounce counters, DIP_STATE to 0; RESET overrides WE/RE in the same cycle.
REQ-031 After reset release, DIP bits held at 1 appear in DIP_STATE after 2+DEBOUNCE_CYCLES cycles and set CHG (reset state is 0).
REQ-032 Reset asserted mid-debounce discards the partial count.

Structure
REQ-033 Shared package io_pkg holds register offset constants (DIP_STATE..SCRATCH) and register-map width constant.
REQ-034 One sub-module, io_debounce (one bit: synchroniser + counter + toggle pulse), instantiated N_DIP times via generate.
REQ-035 Target size 120-400 RTL lines; no latches, no combinational path from DIP to any output.

Verification
REQ-036 Reset: RESET 1 for 2 cycles with DIP=7'b0001100 -> all outputs 0; after 6 cycles DIP_STATE=0x0C, CHG=0x0C, IRQ=0.
REQ-037 Debounce: toggle DIP[0] high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> DIP_STATE[0] stays 0, CHG unchanged; hold 4+ cycles -> bit sets 6 cycles after edge.
REQ-038 Register RW: write LED 0xFFFFA5A5, SEVENSEGHEX 0x12345678 -> LED=0xA5A5, SEVENSEGHEX=0x12345678 next cycle; reads return 0x0000A5A5, 0x12345678 with RVALID one cycle after RE.
REQ-039 IRQ/W1C: CHG_EN=0x01, DIP[0] rise -> IRQ=1; write CHG=0x01 -> IRQ=0; write coinciding with new DIP[0] toggle -> CHG[0] stays 1.
REQ-040 Unmapped/RO: write 0xDEADBEEF to offset 0x18 and 0x00 -> no state change; read 0x1C -> RDATA=0, RVALID=1.
REQ-041 Parameter sweep: N_DIP=32, N_LED=8, DEBOUNCE_CYCLES=2 -> REQ-036..040 pass with widths scaled.
